// File: rtl/inst_mem_sync.sv
// Synchronous-read instruction memory for the pipelined MIPS IF stage with hold/flush and a program-load port.
// Optional power-on clear sweep enabled by defining INST_MEM_BOOTCLR_EN.
module inst_mem_sync #(
   parameter int               WIDTH    = 32,
   parameter int               DEPTH    = 32,
   parameter int               PC_W     = 32,
   parameter logic [WIDTH-1:0] NOP_WORD = '0
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      fetch_en,
   input  logic                      stall,
   input  logic                      flush,
   input  logic [PC_W-1:0]           pc,
   output logic [WIDTH-1:0]          inst,
   output logic                      inst_valid,
   output logic                      addr_err,
   input  logic                      prog_we,
   input  logic [$clog2(DEPTH)-1:0]  prog_addr,
   input  logic [WIDTH-1:0]          prog_data,
   output logic                      ready
);

   localparam int ADDR_W = $clog2(DEPTH);

   logic [WIDTH-1:0]  mem_q [DEPTH];
   logic [WIDTH-1:0]  inst_q;
   logic              valid_q;
   logic              err_q;

   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [WIDTH-1:0]  wr_data;

   logic [ADDR_W-1:0] rd_idx;
   logic              hi_err;
   logic              pc_err;

   assign rd_idx = pc[ADDR_W+1:2];

   // Any PC bit above the word index means the fetch is out of range; no aliasing.
   if (PC_W > ADDR_W + 2) begin : g_hi_chk
      assign hi_err = |pc[PC_W-1:ADDR_W+2];
   end else begin : g_no_hi_chk
      assign hi_err = 1'b0;
   end

   assign pc_err = (pc[1:0] != 2'b00) || hi_err;

`ifdef INST_MEM_BOOTCLR_EN
   typedef enum logic {S_CLEAR, S_RUN} state_t;

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

   state_t            state_q;
   logic [ADDR_W-1:0] clr_cnt_q;
   logic              ready_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_CLEAR;
         clr_cnt_q <= '0;
         ready_q   <= 1'b0;
      end else begin
         case (state_q)
            S_CLEAR: begin
               clr_cnt_q <= clr_cnt_q + 1'b1;
               if (clr_cnt_q == LAST_IDX) begin
                  state_q <= S_RUN;
                  ready_q <= 1'b1;
               end
            end
            default: begin
               state_q <= S_RUN;
               ready_q <= 1'b1;
            end
         endcase
      end
   end

   // The sweep owns the write port; loader writes are dropped until it finishes.
   always_comb begin
      wr_en   = 1'b0;
      wr_addr = prog_addr;
      wr_data = prog_data;
      if (state_q == S_CLEAR) begin
         wr_en   = 1'b1;
         wr_addr = clr_cnt_q;
         wr_data = NOP_WORD;
      end else if (prog_we) begin
         wr_en   = 1'b1;
      end
   end

   assign ready = ready_q;
`else
   assign ready   = 1'b1;
   assign wr_en   = prog_we;
   assign wr_addr = prog_addr;
   assign wr_data = prog_data;
`endif

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_addr] <= wr_data;
      end
   end

   // Read happens in the same edge as a colliding write, so the old word is returned.
   always_ff @(posedge clk) begin
      if (rst) begin
         inst_q  <= NOP_WORD;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
      end else if (flush) begin
         inst_q  <= NOP_WORD;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
      end else if (stall) begin
         inst_q  <= inst_q;
         valid_q <= valid_q;
         err_q   <= err_q;
      end else if (fetch_en && ready) begin
         if (pc_err) begin
            inst_q  <= NOP_WORD;
            valid_q <= 1'b1;
            err_q   <= 1'b1;
         end else begin
            inst_q  <= mem_q[rd_idx];
            valid_q <= 1'b1;
            err_q   <= 1'b0;
         end
      end else if (fetch_en) begin
         inst_q  <= NOP_WORD;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         err_q   <= 1'b0;
      end
   end

   assign inst       = inst_q;
   assign inst_valid = valid_q;
   assign addr_err   = err_q;

endmodule

// File: tb/tb_inst_mem_sync.sv
// Self-checking bench for inst_mem_sync: directed scenarios plus randomized traffic against a behavioural model.
// Define INST_MEM_BOOTCLR_EN to also exercise the clear sweep.
module tb_inst_mem_sync;

   localparam int DEPTH = 32;
`ifdef INST_MEM_BOOTCLR_EN
   localparam bit BOOTCLR = 1'b1;
`else
   localparam bit BOOTCLR = 1'b0;
`endif

   logic        clk;
   logic        rst;
   logic        fetch_en;
   logic        stall;
   logic        flush;
   logic [31:0] pc;
   logic [31:0] inst;
   logic        inst_valid;
   logic        addr_err;
   logic        prog_we;
   logic [4:0]  prog_addr;
   logic [31:0] prog_data;
   logic        ready;

   int checks;
   int errors;

   // Behavioural model state
   logic [31:0] m_mem [DEPTH];
   logic [31:0] m_inst;
   logic        m_valid;
   logic        m_err;
   logic        m_ready;
   int          m_clear_left;

   inst_mem_sync #(.WIDTH(32), .DEPTH(DEPTH), .PC_W(32), .NOP_WORD(32'h0)) dut (
      .clk        (clk),
      .rst        (rst),
      .fetch_en   (fetch_en),
      .stall      (stall),
      .flush      (flush),
      .pc         (pc),
      .inst       (inst),
      .inst_valid (inst_valid),
      .addr_err   (addr_err),
      .prog_we    (prog_we),
      .prog_addr  (prog_addr),
      .prog_data  (prog_data),
      .ready      (ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one edge, update the model from the rules, then settle before sampling.
   task automatic tick();
      bit bad_pc;
      @(posedge clk);
      bad_pc = ((pc % 4) != 0) || (pc >= 32'(DEPTH * 4));
      if (rst) begin
         m_inst = 32'h0; m_valid = 1'b0; m_err = 1'b0;
      end else if (flush) begin
         m_inst = 32'h0; m_valid = 1'b0; m_err = 1'b0;
      end else if (stall) begin
         // hold
      end else if (fetch_en && m_ready) begin
         if (bad_pc) begin
            m_inst = 32'h0; m_valid = 1'b1; m_err = 1'b1;
         end else begin
            m_inst = m_mem[pc / 4]; m_valid = 1'b1; m_err = 1'b0;
         end
      end else if (fetch_en) begin
         m_inst = 32'h0; m_valid = 1'b0; m_err = 1'b0;
      end else begin
         m_valid = 1'b0; m_err = 1'b0;
      end
      if (prog_we && m_ready) m_mem[prog_addr] = prog_data;
      if (BOOTCLR) begin
         if (rst) begin
            m_clear_left = DEPTH;
            for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'h0;
         end else if (m_clear_left > 0) begin
            m_clear_left--;
         end
         m_ready = (m_clear_left == 0);
      end else begin
         m_ready = 1'b1;
      end
      #1;
   endtask

   task automatic idle_inputs();
      rst = 0; fetch_en = 0; stall = 0; flush = 0; prog_we = 0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1;
      tick();
      rst = 0;
      checks++;
      if ({inst, inst_valid, addr_err} !== {32'h0, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL reset_out: got inst=%h v=%b e=%b want inst=00000000 v=0 e=0", inst, inst_valid, addr_err);
      end
      checks++;
      if (ready !== !BOOTCLR) begin
         errors++;
         $display("FAIL reset_ready: got %b want %b", ready, !BOOTCLR);
      end
      $display("reset: inst=%h v=%b e=%b ready=%b", inst, inst_valid, addr_err, ready);
      for (int i = 0; i < 40 && !m_ready; i++) tick();
      checks++;
      if (ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_ready_final: got %b want 1", ready);
      end
   endtask

   task automatic test_program_load();
      logic [31:0] words [4];
      words[0] = 32'h00000000; words[1] = 32'h00430820;
      words[2] = 32'h08000005; words[3] = 32'h10210003;
      idle_inputs();
      for (int i = 0; i < DEPTH; i++) begin
         prog_we = 1; prog_addr = 5'(i);
         prog_data = (i < 4) ? words[i] : $urandom;
         tick();
      end
      prog_we = 0;
      fetch_en = 1; pc = 32'h4;
      tick();
      fetch_en = 0;
      checks++;
      if ({inst, inst_valid, addr_err} !== {32'h00430820, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL load_fetch4: got inst=%h v=%b e=%b want inst=00430820 v=1 e=0", inst, inst_valid, addr_err);
      end
      $display("load: fetch pc=4 inst=%h v=%b e=%b", inst, inst_valid, addr_err);
   endtask

   task automatic test_stall();
      idle_inputs();
      fetch_en = 1; pc = 32'h8;
      tick();
      stall = 1;
      for (int i = 0; i < 3; i++) begin
         pc = 32'(4 * $urandom_range(0, 31));
         tick();
         checks++;
         if ({inst, inst_valid, addr_err} !== {32'h08000005, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL stall_hold%0d: got inst=%h v=%b want inst=08000005 v=1", i, inst, inst_valid);
         end
         $display("stall %0d: pc=%h inst=%h v=%b", i, pc, inst, inst_valid);
      end
      stall = 0; pc = 32'hC;
      tick();
      checks++;
      if ({inst, inst_valid} !== {32'h10210003, 1'b1}) begin
         errors++;
         $display("FAIL stall_release: got inst=%h v=%b want inst=10210003 v=1", inst, inst_valid);
      end
      $display("stall release: pc=c inst=%h v=%b", inst, inst_valid);
      fetch_en = 0;
      tick();
      checks++;
      if ({inst, inst_valid, addr_err} !== {32'h10210003, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL idle_hold: got inst=%h v=%b e=%b want inst=10210003 v=0 e=0", inst, inst_valid, addr_err);
      end
      $display("idle: inst=%h v=%b", inst, inst_valid);
   endtask

   task automatic test_flush();
      idle_inputs();
      flush = 1; stall = 1; fetch_en = 1; pc = 32'h4;
      tick();
      idle_inputs();
      checks++;
      if ({inst, inst_valid, addr_err} !== {32'h0, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL flush: got inst=%h v=%b e=%b want inst=00000000 v=0 e=0", inst, inst_valid, addr_err);
      end
      $display("flush: inst=%h v=%b e=%b", inst, inst_valid, addr_err);
   endtask

   task automatic test_error();
      logic [31:0] bad [3];
      bad[0] = 32'h6; bad[1] = 32'h80; bad[2] = 32'h80000004;
      idle_inputs();
      for (int i = 0; i < 3; i++) begin
         fetch_en = 1; pc = bad[i];
         tick();
         checks++;
         if ({inst, inst_valid, addr_err} !== {32'h0, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL err_pc_%h: got inst=%h v=%b e=%b want inst=00000000 v=1 e=1", bad[i], inst, inst_valid, addr_err);
         end
         $display("error fetch pc=%h: inst=%h v=%b e=%b", bad[i], inst, inst_valid, addr_err);
      end
      fetch_en = 0;
   endtask

   task automatic test_collision();
      logic [31:0] old_word;
      old_word = m_mem[5];
      idle_inputs();
      prog_we = 1; prog_addr = 5'd5; prog_data = 32'hDEADBEEF;
      fetch_en = 1; pc = 32'h14;
      tick();
      prog_we = 0;
      checks++;
      if ({inst, inst_valid} !== {old_word, 1'b1}) begin
         errors++;
         $display("FAIL collide_old: got inst=%h v=%b want inst=%h v=1", inst, inst_valid, old_word);
      end
      $display("collision: inst=%h (old)", inst);
      tick();
      fetch_en = 0;
      checks++;
      if ({inst, inst_valid} !== {32'hDEADBEEF, 1'b1}) begin
         errors++;
         $display("FAIL collide_new: got inst=%h v=%b want inst=deadbeef v=1", inst, inst_valid);
      end
      $display("collision next fetch: inst=%h", inst);
   endtask

   task automatic test_random();
      for (int n = 0; n < 300; n++) begin
         rst      = ($urandom_range(0, 99) == 0);
         flush    = ($urandom_range(0, 9) == 0);
         stall    = ($urandom_range(0, 5) == 0);
         fetch_en = ($urandom_range(0, 3) != 0);
         case ($urandom_range(0, 9))
            0:       pc = 32'(4 * $urandom_range(0, 31)) | 32'($urandom_range(1, 3));
            1:       pc = $urandom | 32'h80;
            default: pc = 32'(4 * $urandom_range(0, 31));
         endcase
         prog_we   = ($urandom_range(0, 3) == 0);
         prog_addr = 5'($urandom_range(0, 31));
         prog_data = $urandom;
         tick();
         checks++;
         if ({inst, inst_valid, addr_err, ready} !== {m_inst, m_valid, m_err, m_ready}) begin
            errors++;
            $display("FAIL rand_%0d: got inst=%h v=%b e=%b r=%b want inst=%h v=%b e=%b r=%b",
                     n, inst, inst_valid, addr_err, ready, m_inst, m_valid, m_err, m_ready);
         end else begin
            $display("rand %0d: pc=%h inst=%h v=%b e=%b r=%b", n, pc, inst, inst_valid, addr_err, ready);
         end
      end
      idle_inputs();
      for (int i = 0; i < 40 && !m_ready; i++) tick();
   endtask

`ifdef INST_MEM_BOOTCLR_EN
   task automatic test_bootclr();
      int low_cycles;
      idle_inputs();
      rst = 1;
      tick();
      rst = 0;
      low_cycles = 0;
      while (ready !== 1'b1 && low_cycles < 40) begin
         low_cycles++;
         prog_we = 1; prog_addr = 5'($urandom_range(0, 31)); prog_data = 32'hFFFFFFFF;
         fetch_en = 1; pc = 32'(4 * $urandom_range(0, 31));
         tick();
         if (ready !== 1'b1) begin
            checks++;
            if (inst_valid !== 1'b0) begin
               errors++;
               $display("FAIL clr_fetch_ignored: got v=%b want 0", inst_valid);
            end
         end
      end
      idle_inputs();
      checks++;
      if (low_cycles != DEPTH) begin
         errors++;
         $display("FAIL clr_len: got %0d low cycles want %0d", low_cycles, DEPTH);
      end
      $display("bootclr sweep: ready low %0d cycles", low_cycles);
      for (int i = 0; i < DEPTH; i++) begin
         fetch_en = 1; pc = 32'(4 * i);
         tick();
         checks++;
         if ({inst, inst_valid, addr_err} !== {32'h0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL clr_word%0d: got inst=%h v=%b e=%b want inst=00000000 v=1 e=0", i, inst, inst_valid, addr_err);
         end
      end
      idle_inputs();
      rst = 1;
      tick();
      rst = 0;
      for (int i = 0; i < 10; i++) tick();
      rst = 1;
      tick();
      rst = 0;
      low_cycles = 0;
      while (ready !== 1'b1 && low_cycles < 40) begin
         low_cycles++;
         tick();
      end
      checks++;
      if (low_cycles != DEPTH) begin
         errors++;
         $display("FAIL clr_restart_len: got %0d low cycles want %0d", low_cycles, DEPTH);
      end
      $display("bootclr restart: ready low %0d cycles", low_cycles);
   endtask
`endif

   initial begin
      checks = 0; errors = 0;
      rst = 1; fetch_en = 0; stall = 0; flush = 0; prog_we = 0;
      pc = '0; prog_addr = '0; prog_data = '0;
      m_inst = 32'h0; m_valid = 1'b0; m_err = 1'b0;
      m_ready = !BOOTCLR; m_clear_left = 0;
      for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'h0;
      @(negedge clk);
      test_reset();
      test_program_load();
      test_stall();
      test_flush();
      test_error();
      test_collision();
`ifdef INST_MEM_BOOTCLR_EN
      test_bootclr();
      test_program_load();
`endif
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/inst_mem_sync.md
Name: inst_mem_sync

Overview:
Parametrised, writable instruction memory for the pipelined MIPS core. It replaces the fixed 32-word combinational ROM in the IF stage.
- Synchronous read with 1-cycle latency; hold (stall) and flush controls come from the hazard unit.
- A program-load port lets the bench or a loader write instructions at run time.
- Misaligned and out-of-range PCs are flagged.

Parameters:
WIDTH, 32, instruction word width in bits.
DEPTH, 32, number of words; must be a power of 2, at least 2. ADDR_W = clog2(DEPTH) is a localparam.
PC_W, 32, PC (byte address) width; must be at least ADDR_W+2.
NOP_WORD, 32'h00000000, word driven on flush, on error and after reset.

Ports:
clk  in  1  clock; all state changes on the rising edge.
rst  in  1  synchronous, active-high reset.
fetch_en  in  1  request a fetch of pc this cycle.
stall  in  1  hold the current inst/inst_valid/addr_err.
flush  in  1  squash the output; next inst is NOP_WORD.
pc  in  PC_W  byte address; word index = pc[ADDR_W+1:2].
inst  out  WIDTH  registered instruction.
inst_valid  out  1  inst holds a fetched word.
addr_err  out  1  the fetch that produced inst was misaligned or out of range.
prog_we  in  1  program-load write enable.
prog_addr  in  ADDR_W  program-load word index.
prog_data  in  WIDTH  program-load data.
ready  out  1  memory accepts fetches and writes.

Behaviour:
- Reset (sync, active-high): inst=NOP_WORD, inst_valid=0, addr_err=0, ready=1 (see optional feature). Memory contents are not cleared without the optional feature.
- Output update priority each edge: rst > flush > stall > fetch_en > idle.
- flush=1: inst=NOP_WORD, inst_valid=0, addr_err=0. Flush wins over a simultaneous stall and fetch_en.
- stall=1 (no flush): inst, inst_valid and addr_err hold their values.
- fetch_en=1 (no stall/flush): on the next edge inst=mem[pc[ADDR_W+1:2]], inst_valid=1, addr_err=0. Latency is exactly 1 cycle.
- Error fetch: pc[1:0]!=0, or any pc bit at or above ADDR_W+2 is set. Result: inst=NOP_WORD, inst_valid=1, addr_err=1. Memory is not read.
- Idle (fetch_en=0, no stall/flush): inst_valid=0, addr_err=0, inst holds its value.
- Write: prog_we=1 with ready=1 writes mem[prog_addr]=prog_data at the edge. Writes are independent of stall/flush and are performed even in the rst cycle.
- Read/write collision (same cycle, same word): read-first. inst gets the old contents; the new word is visible to the next fetch.
- prog_we with ready=0: the write is ignored (dropped).
- Wrap-around: none. Addresses at or above DEPTH words raise the error and do not alias.

Optional Feature:
INST_MEM_BOOTCLR_EN
- Defined: rst starts a clear sweep. An internal ADDR_W-bit counter writes NOP_WORD to words 0..DEPTH-1, one per cycle, over DEPTH cycles.
  - FSM: CLEAR -> RUN.
  - ready=0 in CLEAR; ready=1 on the cycle after word DEPTH-1 is written.
  - During CLEAR: fetch_en is ignored (inst=NOP_WORD, inst_valid=0), prog_we is dropped, flush/stall act as usual.
  - rst during CLEAR restarts the sweep from word 0.
- Undefined: no counter; ready is tied to 1; contents after reset are undefined until written.

Test Plan:
- Load words 0..3 with 0x00000000, 0x00430820, 0x08000005, 0x10210003; fetch pc=0x4 -> next cycle inst=0x00430820, inst_valid=1, addr_err=0.
- Fetch pc=0x8, then stall=1 for 3 cycles with pc changing -> inst stays 0x08000005, inst_valid=1; release stall with fetch_en, pc=0xC -> inst=0x10210003.
- flush=1 with stall=1 and fetch_en=1 -> next cycle inst=0x00000000, inst_valid=0.
- Fetch pc=0x6 (misaligned) and pc=0x80 with DEPTH=32 -> inst=0x00000000, inst_valid=1, addr_err=1 in each case.
- Same cycle: prog_we to word 5 with 0xDEADBEEF and fetch pc=0x14 -> old word returned; next fetch of pc=0x14 returns 0xDEADBEEF.
- With INST_MEM_BOOTCLR_EN, DEPTH=32: rst pulse -> ready=0 for 32 cycles, prog_we dropped during the sweep; then every fetch returns 0x00000000. Reassert rst mid-sweep -> ready low for a further 32 cycles.
